// File: rtl/legv8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// legv8_mem_arbiter
//
// Shares the single-port unified memory of the LEGv8 multi-cycle core between
// the instruction-fetch requester (IF) and the load/store requester (data).
// One access is in flight at a time. The winner's address, write enable and
// write data are registered onto mem_* when the access is granted. The access
// lasts WAIT_CYCLES cycles; read data is captured on the last access cycle.
// A one-cycle ack then goes to the requester that owned the access.
//
// Handshake (both requesters):
//   - A requester raises req with stable addr/we/wdata and holds it.
//   - The ack is a single-cycle pulse. The registered rdata is valid in that
//     same cycle.
//   - The requester drops req at the clock edge that ends the ack cycle.
//   - A req still high in the IDLE cycle after the ack is a new request.
//   - Request inputs are only looked at in IDLE. Changes during ACCESS/RESP
//     do not affect the access in flight.
//
// Parameters:
//   ADDR_W       byte address width
//   DATA_W       data width
//   WAIT_CYCLES  memory latency in cycles, legal range 1..15 (4-bit counter)
//
// Ports:
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   if_req/if_addr          fetch request and address
//   if_ack/if_rdata         fetch ack pulse and registered fetched word
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_ack/d_rdata           data ack pulse and registered load data
//                           (d_rdata is left unchanged by a store)
//   mem_en/mem_we           memory enable / write enable (ACCESS only)
//   mem_addr/mem_wdata      registered address / write data
//   mem_rdata               memory read data, valid on the last ACCESS cycle
//   busy                    high in ACCESS and RESP
//   state_dbg               FSM state for observation: 0 IDLE, 1 ACCESS, 2 RESP
//
// Configuration macro:
//   LEGV8_ARB_ROUND_ROBIN_EN
//     - undefined: fixed priority; data beats fetch on a tie.
//     - defined: round robin; on a tie the requester not granted last time
//       wins. last_grant resets to IF, so the first tie goes to data.
// -----------------------------------------------------------------------------
module legv8_mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  // memory macro side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Counter load value. WAIT_CYCLES=1 loads 0, which gives one ACCESS cycle.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  localparam logic OWNER_IF   = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  state_t      state;
  state_t      state_nx;

  logic        owner;        // requester of the access in flight
  logic [3:0]  cnt;          // remaining ACCESS cycles minus one
  logic        we_q;         // write enable latched at grant

  logic        grant;        // a request is accepted this cycle (IDLE only)
  logic        grant_data;   // 1: data wins the grant, 0: fetch wins
  logic        access_done;  // last ACCESS cycle; read data is valid

  // ---------------------------------------------------------------------------
  // Arbitration. This only matters in IDLE. A single request always wins.
  // ---------------------------------------------------------------------------
`ifdef LEGV8_ARB_ROUND_ROBIN_EN
  logic last_grant;          // 0: IF was granted last, 1: data was

  // On a tie, data wins exactly when IF was the last one granted.
  always_comb begin
    grant_data = d_req & (~if_req | ~last_grant);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= OWNER_IF;
    end else if (grant) begin
      last_grant <= grant_data;
    end
  end
`else
  // Fixed priority: data beats fetch, so a pending load/store never stalls
  // behind an instruction fetch.
  always_comb begin
    grant_data = d_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs.
  // mem_en/mem_we/acks/busy are decoded from the state register. An
  // asynchronous reset therefore drops them at once, without waiting for a
  // clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    grant       = 1'b0;
    access_done = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    if_ack      = 1'b0;
    d_ack       = 1'b0;
    busy        = 1'b0;

    case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant    = 1'b1;
          state_nx = S_ACCESS;
        end
      end

      S_ACCESS: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        mem_we = (owner == OWNER_DATA) & we_q;
        if (cnt == 4'd0) begin
          access_done = 1'b1;
          state_nx    = S_RESP;
        end
      end

      S_RESP: begin
        // Requests are ignored here. A req still high after the ack is taken
        // as a fresh request in the next IDLE cycle.
        busy     = 1'b1;
        if_ack   = (owner == OWNER_IF);
        d_ack    = (owner == OWNER_DATA);
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Access datapath: latch the winner's command at grant, count the latency,
  // and capture read data on the final ACCESS cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner     <= OWNER_IF;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant) begin
        owner <= grant_data;
        cnt   <= CNT_LOAD;
        if (grant_data) begin
          we_q      <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          // A fetch never writes. Clearing the write data keeps stale
          // store data off the memory bus.
          we_q      <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end else if ((state == S_ACCESS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      // Only fetches and loads update a read-data register. d_rdata keeps
      // the last load result across stores.
      if (access_done) begin
        if (owner == OWNER_IF) begin
          if_rdata <= mem_rdata;
        end else if (!we_q) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_legv8_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_legv8_mem_arbiter
//
// Bench for legv8_mem_arbiter (WAIT_CYCLES = 2). It drives two requesters
// against a 16-word memory model that is indexed by address bits [6:3].
// Results are compared against values the bench derives itself:
//   - table vectors for single and simultaneous requests
//   - hand sequences for reset mid-access, held fetches and held ties
//   - a randomized run checked by a transaction-level model. The model knows
//     only the timing rules: a grant in IDLE at cycle t acks at t+W+1, and the
//     arbiter is free again at t+W+2.
// -----------------------------------------------------------------------------
module tb_legv8_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int WAIT   = 2;
  localparam int EXP_W  = DATA_W + 1;   // {owner_is_data, expected rdata}

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              if_ack, d_ack, mem_en, mem_we, busy;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        state_dbg;

  legv8_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // memory model: combinational read, write on the clock edge while enabled.
  // The poke port preloads contents while the DUT is held in reset.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_arr [16];
  logic              poke_en;
  logic [3:0]        poke_idx;
  logic [DATA_W-1:0] poke_data;

  assign mem_rdata = mem_arr[mem_addr[6:3]];

  always @(posedge clock) begin
    if (poke_en) mem_arr[poke_idx] <= poke_data;
    else if (mem_en && mem_we) mem_arr[mem_addr[6:3]] <= mem_wdata;
  end

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 8) return 64'h0000_0000_D503_201F;
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  // ---------------------------------------------------------------------------
  // scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int total;
  int bad;
  logic [DATA_W-1:0] shadow [16];       // bench's own view of memory contents
  logic [EXP_W-1:0]  exp_q[$];          // expected acks, oldest first
  int                exp_cyc_q[$];      // cycle each expected ack is due

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  // Returns at posedge+1, i.e. early in the first IDLE cycle after reset.
  task automatic do_reset();
    reset  = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  // ---------------------------------------------------------------------------
  // table-driven vectors: requests raised together in cycle 0, held until ack
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              if_on;
    logic              d_on;
    logic              d_we;
    logic [ADDR_W-1:0] if_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    int                exp_if_lat;     // cycles from request to if_ack, -1 none
    int                exp_d_lat;
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int n, input vec_t v);
    int if_lat, d_lat, en_cnt, we_cnt, wd_bad;
    logic [DATA_W-1:0] if_rd, d_rd;
    logic saw_if, saw_d;
    if_lat = -1; d_lat = -1; en_cnt = 0; we_cnt = 0; wd_bad = 0;
    if_rd = '0; d_rd = '0;
    do_reset();
    if_req = v.if_on; if_addr = v.if_addr;
    d_req = v.d_on; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    for (int c = 0; c < 4 * WAIT + 12; c++) begin
      @(negedge clock);
      if (mem_en) en_cnt++;
      if (mem_we) begin
        we_cnt++;
        if (mem_wdata !== v.d_wdata || mem_addr !== v.d_addr) wd_bad++;
      end
      saw_if = if_ack;
      saw_d  = d_ack;
      if (if_ack && if_lat < 0) begin if_lat = c; if_rd = if_rdata; end
      if (d_ack && d_lat < 0) begin d_lat = c; d_rd = d_rdata; end
      next_cycle();
      if (saw_if) if_req = 1'b0;
      if (saw_d) d_req = 1'b0;
    end
    check($sformatf("v%0d_if_lat", n), 64'(if_lat), 64'(v.exp_if_lat));
    check($sformatf("v%0d_d_lat", n), 64'(d_lat), 64'(v.exp_d_lat));
    if (v.if_on) check($sformatf("v%0d_if_rdata", n), if_rd, v.exp_if_rdata);
    if (v.d_on) check($sformatf("v%0d_d_rdata", n), d_rd, v.exp_d_rdata);
    check($sformatf("v%0d_en_cycles", n), 64'(en_cnt), 64'(WAIT * (int'(v.if_on) + int'(v.d_on))));
    check($sformatf("v%0d_we_cycles", n), 64'(we_cnt), 64'((v.d_on && v.d_we) ? WAIT : 0));
    check($sformatf("v%0d_wdata_bad", n), 64'(wd_bad), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // randomized run with a transaction-level reference model
  // ---------------------------------------------------------------------------
  function automatic logic [ADDR_W-1:0] rand_addr();
    return {32'($urandom), 25'($urandom), 4'($urandom_range(0, 15)), 3'b000};
  endfunction

  task automatic run_random(input int ncyc);
    int               next_idle;
    int               drain;
    logic             lg;          // last grant, 1 = data
    logic             who;
    logic [3:0]       idx;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_d_rd;   // d_rdata expected to persist across stores
    logic [EXP_W-1:0] e;
    logic             saw_if, saw_d;
    next_idle = 0; lg = 1'b0; saw_if = 1'b0; saw_d = 1'b0;
    drain = 4 * (WAIT + 2) + 4;
    exp_d_rd = '0;
    do_reset();
    for (int c = 0; c < ncyc + drain; c++) begin
      // requesters: drop after ack, then maybe issue a new request
      if (saw_if) if_req = 1'b0;
      if (saw_d) d_req = 1'b0;
      if (c < ncyc) begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = rand_addr();
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
          d_wdata = {$urandom, $urandom};
        end
      end
      // model: a grant happens whenever the arbiter is free and someone asks
      if (c >= next_idle && (if_req || d_req)) begin
`ifdef LEGV8_ARB_ROUND_ROBIN_EN
        who = (if_req && d_req) ? ~lg : d_req;
`else
        who = d_req;
`endif
        lg  = who;
        idx = who ? d_addr[6:3] : if_addr[6:3];
        if (who && d_we) begin
          shadow[idx] = d_wdata;
          data = exp_d_rd;
        end else begin
          data = shadow[idx];
          if (who) exp_d_rd = data;
        end
        exp_q.push_back({who, data});
        exp_cyc_q.push_back(c + WAIT + 1);
        next_idle = c + WAIT + 2;
      end
      @(negedge clock);
      saw_if = if_ack;
      saw_d  = d_ack;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == c) begin
        e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("rnd_if_ack", 64'(if_ack), 64'(!e[DATA_W]));
        check("rnd_d_ack", 64'(d_ack), 64'(e[DATA_W]));
        if (e[DATA_W]) check("rnd_d_rdata", d_rdata, e[DATA_W-1:0]);
        else check("rnd_if_rdata", if_rdata, e[DATA_W-1:0]);
      end else begin
        check("rnd_no_ack", 64'({if_ack, d_ack}), 64'd0);
      end
      next_cycle();
    end
    check("rnd_drained", 64'(exp_q.size()), 64'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ack_cyc[$];
    logic ord[$];
    int lat, busy_low, both_cnt;
    logic exp_order [4];
    logic saw_if, saw_d, any_d;

    total = 0; bad = 0;
    reset = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    poke_en = 1'b0; poke_idx = '0; poke_data = '0;

    // preload memory while the DUT is held in reset
    for (int i = 0; i < 16; i++) begin
      poke_en = 1'b1; poke_idx = 4'(i); poke_data = init_word(i);
      shadow[i] = init_word(i);
      next_cycle();
    end
    poke_en = 1'b0;

    // reset state
    @(negedge clock);
    check("rst_acks", 64'({if_ack, d_ack}), 64'd0);
    check("rst_mem_en_we", 64'({mem_en, mem_we}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state_idle", 64'(state_dbg), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_if_rdata", if_rdata, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);

    // table vectors (W+1 for a lone or winning request, 2W+3 for the loser)
    vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 64'h0,
                WAIT + 1, -1, 64'h0000_0000_D503_201F, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h08, 64'h0,
                -1, WAIT + 1, 64'h0, 64'hA5A5_0000_0000_0001};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h100, 64'h1234,
                -1, WAIT + 1, 64'h0, 64'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 64'h48, 64'h100, 64'h0,
                2 * WAIT + 3, WAIT + 1, 64'hA5A5_0000_0000_0009, 64'h1234};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 64'h40, 64'h18, 64'hBEEF,
                2 * WAIT + 3, WAIT + 1, 64'h0000_0000_D503_201F, 64'h0};
    for (int n = 0; n < 5; n++) begin
      run_vec(n, vecs[n]);
      if (n == 2) check("store_landed", mem_arr[0], 64'h1234);
    end
    shadow[0] = 64'h1234;
    shadow[3] = 64'hBEEF;

    // reset in the 2nd ACCESS cycle of a store, with a fetch also pending
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h28; d_wdata = 64'hDEAD;
    if_req = 1'b1; if_addr = 64'h40;
    next_cycle();          // ACCESS 1
    next_cycle();          // ACCESS 2
    #2;
    check("abort_pre_mem_we", 64'({mem_en, mem_we}), 64'b11);
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    check("abort_mem_en_we", 64'({mem_en, mem_we}), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state_idle", 64'(state_dbg), 64'd0);
    @(negedge clock);
    check("abort_no_ack", 64'({if_ack, d_ack}), 64'd0);
    // the first ACCESS edge already committed the store in this memory model
    shadow[5] = 64'hDEAD;
    next_cycle();
    reset = 1'b0;
    lat = -1; any_d = 1'b0;
    for (int c = 0; c < 4 * WAIT + 10; c++) begin
      @(negedge clock);
      saw_if = if_ack;
      if (d_ack) any_d = 1'b1;
      if (if_ack && lat < 0) begin
        lat = c;
        check("abort_if_rdata", if_rdata, 64'h0000_0000_D503_201F);
      end
      next_cycle();
      if (saw_if) if_req = 1'b0;
    end
    check("abort_if_lat", 64'(lat), 64'(WAIT + 1));
    check("abort_no_d_ack", 64'(any_d), 64'd0);

    // back-to-back fetches with if_req held: ack every W+2 cycles
    do_reset();
    if_req = 1'b1; if_addr = 64'h40;
    ack_cyc.delete();
    busy_low = 0;
    for (int c = 0; c < 3 * (WAIT + 2); c++) begin
      @(negedge clock);
      if (if_ack) ack_cyc.push_back(c);
      if (!busy) busy_low++;
      next_cycle();
    end
    if_req = 1'b0;
    check("b2b_ack_count", 64'(ack_cyc.size()), 64'd3);
    for (int k = 0; k < 3 && k < ack_cyc.size(); k++)
      check($sformatf("b2b_ack%0d_cycle", k), 64'(ack_cyc[k]), 64'(k * (WAIT + 2) + WAIT + 1));
    check("b2b_busy_low", 64'(busy_low), 64'd3);

    // both requests held continuously: grant order depends on the arbiter mode
`ifdef LEGV8_ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    if_req = 1'b1; if_addr = 64'h48;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
    ack_cyc.delete(); ord.delete(); both_cnt = 0;
    for (int c = 0; c < 4 * (WAIT + 2); c++) begin
      @(negedge clock);
      if (if_ack && d_ack) both_cnt++;
      if (if_ack || d_ack) begin ack_cyc.push_back(c); ord.push_back(d_ack); end
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    check("tie_both_acks", 64'(both_cnt), 64'd0);
    check("tie_ack_count", 64'(ack_cyc.size()), 64'd4);
    for (int k = 0; k < 4 && k < ack_cyc.size(); k++) begin
      check($sformatf("tie_ack%0d_cycle", k), 64'(ack_cyc[k]), 64'(k * (WAIT + 2) + WAIT + 1));
      check($sformatf("tie_ack%0d_owner", k), 64'(ord[k]), 64'(exp_order[k]));
    end

    // randomized traffic against the reference model
    run_random(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
